// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: select encodings, flag bit
// positions and the control part of a command FIFO entry.
// Build option: ALU_CARRY_CHAIN_EN adds a per-entry chain bit.
package alu_pkg;

  // ALU operation select encodings (passed through to the ALU unmodified)
  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_NOT  = 4'b0010;
  localparam logic [3:0] SEL_NOR  = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_NAND = 4'b0101;

  // Bit positions inside res_flags = {Cout, Negative, Zero, Overflow}
  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  // Control fields stored with each FIFO entry; operands travel alongside.
  typedef struct packed {
    logic [3:0] sel;
    logic       cin;
`ifdef ALU_CARRY_CHAIN_EN
    logic       chain;
`endif
  } cmd_ctl_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with push/pop, internal full, empty and count.
// Pushes while full and pops while empty are ignored, so a push on a full
// FIFO is dropped even when a pop happens on the same edge.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                din,
  output logic [DW-1:0]                dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full, do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue / result-capture wrapper around a combinational ALU.
// Commands queue in alu_cmd_fifo, S1 registers drive the ALU inputs, S2
// captures Y and flags with valid/ready backpressure toward the consumer.
// Build option: ALU_CARRY_CHAIN_EN adds cmd_chain and a carry register so a
// chained command takes the previous Cout as its carry in.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [3:0]   cmd_sel,
  input  logic         cmd_cin,
`ifdef ALU_CARRY_CHAIN_EN
  input  logic         cmd_chain,
`endif
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  output logic         alu_cin,
  input  logic [W-1:0] alu_y,
  input  logic         alu_cout,
  input  logic         alu_neg,
  input  logic         alu_zero,
  input  logic         alu_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic [3:0]   res_flags
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = 2 * W + $bits(cmd_ctl_t);

  cmd_ctl_t      push_ctl, head_ctl;
  logic [W-1:0]  head_a, head_b;
  logic [DW-1:0] fifo_din, fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, push, issue, s1_adv, s2_adv, issue_cin;
  logic [3:0]    capt_flags;

  logic          s1_valid_reg;
  logic [W-1:0]  alu_a_reg, alu_b_reg, res_y_reg;
  logic [3:0]    alu_sel_reg, res_flags_reg;
  logic          alu_cin_reg, res_valid_reg;

  // Pack the incoming command's control fields
  always_comb begin
    push_ctl     = '0;
    push_ctl.sel = cmd_sel;
    push_ctl.cin = cmd_cin;
`ifdef ALU_CARRY_CHAIN_EN
    push_ctl.chain = cmd_chain;
`endif
  end

  assign fifo_din  = {cmd_a, cmd_b, push_ctl};
  assign cmd_ready = !rst && (fifo_count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  // Pipeline advance: S2 frees when empty or consumed, S1 when S2 can take it
  assign s2_adv = !res_valid_reg || res_ready;
  assign s1_adv = !s1_valid_reg || s2_adv;
  assign issue  = !fifo_empty && s1_adv;

  alu_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Unpack the FIFO head
  always_comb begin
    {head_a, head_b, head_ctl} = fifo_dout;
  end

`ifdef ALU_CARRY_CHAIN_EN
  logic carry_reg;

  // Carry register remembers the Cout of the most recently captured op
  always_ff @(posedge clk) begin
    if (rst)                          carry_reg <= 1'b0;
    else if (s1_valid_reg && s2_adv)  carry_reg <= alu_cout;
  end

  // Chained ops take the live Cout when its producer is still in S1
  always_comb begin
    issue_cin = head_ctl.cin;
    if (head_ctl.chain) issue_cin = s1_valid_reg ? alu_cout : carry_reg;
  end
`else
  // Carry in comes straight from the command
  always_comb begin
    issue_cin = head_ctl.cin;
  end
`endif

  // S1: load the FIFO head into the ALU operand registers; hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_sel_reg  <= '0;
      alu_cin_reg  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= !fifo_empty;
      if (!fifo_empty) begin
        alu_a_reg   <= head_a;
        alu_b_reg   <= head_b;
        alu_sel_reg <= head_ctl.sel;
        alu_cin_reg <= issue_cin;
      end
    end
  end

  // Pack the ALU flags into their result positions
  always_comb begin
    capt_flags        = '0;
    capt_flags[FLG_C] = alu_cout;
    capt_flags[FLG_N] = alu_neg;
    capt_flags[FLG_Z] = alu_zero;
    capt_flags[FLG_V] = alu_ovf;
  end

  // S2: capture ALU result when S1 holds an op and the result slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_y_reg     <= '0;
      res_flags_reg <= '0;
    end else if (s2_adv) begin
      res_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        res_y_reg     <= alu_y;
        res_flags_reg <= capt_flags;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign alu_cin   = alu_cin_reg;
  assign res_valid = res_valid_reg;
  assign res_y     = res_y_reg;
  assign res_flags = res_flags_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the alu_* bus.
// Select 4'b1000 is an ADD in the bench ALU so carry/overflow can be driven.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam logic [3:0] SEL_ADD = 4'b1000;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready, cmd_cin;
  logic [W-1:0] cmd_a, cmd_b;
  logic [3:0]   cmd_sel;
`ifdef ALU_CARRY_CHAIN_EN
  logic         cmd_chain;
`endif
  logic [W-1:0] alu_a, alu_b, alu_y, res_y;
  logic [3:0]   alu_sel, res_flags;
  logic         alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
  logic         res_valid, res_ready;
  logic [W:0]   sum;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] sa [8];
  logic [W-1:0] sb [8];
  logic [W-1:0] ba [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_y    = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    sum      = '0;
    case (alu_sel)
      SEL_AND:  alu_y = alu_a & alu_b;
      SEL_OR:   alu_y = alu_a | alu_b;
      SEL_NOT:  alu_y = ~alu_a;
      SEL_NOR:  alu_y = ~(alu_a | alu_b);
      SEL_XOR:  alu_y = alu_a ^ alu_b;
      SEL_NAND: alu_y = ~(alu_a & alu_b);
      SEL_ADD: begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        alu_y    = sum[W-1:0];
        alu_cout = sum[W];
        alu_ovf  = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
      end
      default:  alu_y = '0;
    endcase
    alu_neg  = alu_y[W-1];
    alu_zero = (alu_y == '0);
  end

  alu_issue_stage #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .cmd_cin   (cmd_cin),
`ifdef ALU_CARRY_CHAIN_EN
    .cmd_chain (cmd_chain),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_cin   (alu_cin),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .alu_neg   (alu_neg),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_flags (res_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sel, input logic cin);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_cin   = cin;
  endtask

  // One op through an empty pipe: push at t, S1 at t+1, result at t+2
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sel, input logic cin,
                         input logic [W-1:0] ey, input logic [3:0] ef);
    drive(a, b, sel, cin);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, " res_valid t"}, 64'(res_valid), 64'd0);
    tick();
    chk({tag, " alu_a"}, 64'(alu_a), 64'(a));
    chk({tag, " alu_b"}, 64'(alu_b), 64'(b));
    chk({tag, " alu_sel"}, 64'(alu_sel), 64'(sel));
    chk({tag, " alu_cin"}, 64'(alu_cin), 64'(cin));
    chk({tag, " res_valid t+1"}, 64'(res_valid), 64'd0);
    tick();
    chk({tag, " res_valid t+2"}, 64'(res_valid), 64'd1);
    chk({tag, " res_y"}, 64'(res_y), 64'(ey));
    chk({tag, " res_flags"}, 64'(res_flags), 64'(ef));
    $display("op %s a=%h b=%h sel=%b cin=%b -> y=%h flags=%b", tag, a, b, sel, cin, res_y, res_flags);
    tick();
    chk({tag, " res_valid drop"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_cin = 1'b0;
    res_ready = 1'b0;
`ifdef ALU_CARRY_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      sa[i] = (32'h1111_1111 * (i + 1)) ^ 32'hA5A5_0000;
      sb[i] = 32'h0F0F_3C3C + i;
    end
    for (int i = 0; i < 7; i++) ba[i] = 32'hB000_0000 + i;

    // Reset state
    tick(); tick(); tick();
    chk("rst cmd_ready low", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst res_y", 64'(res_y), 64'd0);
    chk("rst res_flags", 64'(res_flags), 64'd0);
    chk("rst alu_a", 64'(alu_a), 64'd0);
    chk("rst alu_sel", 64'(alu_sel), 64'd0);
    chk("rst alu_cin", 64'(alu_cin), 64'd0);

    // Single op and a handful of flag corner cases
    res_ready = 1'b1;
    run_one("single", 32'hF0F0_F0F0, 32'hFF00_FF00, SEL_AND, 1'b0, 32'hF000_F000, 4'b0100);
    chk("single Z flag", 64'(res_flags[FLG_Z]), 64'd0);
    run_one("and_zero", 32'hF0F0_F0F0, 32'h0F0F_0F0F, SEL_AND, 1'b0, 32'h0000_0000, 4'b0010);
    run_one("add_ovf", 32'h7FFF_FFFF, 32'h0000_0000, SEL_ADD, 1'b1, 32'h8000_0000, 4'b0101);
    run_one("not", 32'h0000_0000, 32'h1234_5678, SEL_NOT, 1'b0, 32'hFFFF_FFFF, 4'b0100);
    run_one("nand", 32'hFFFF_FFFF, 32'hFFFF_FFFF, SEL_NAND, 1'b0, 32'h0000_0000, 4'b0010);
    run_one("add_cout", 32'hFFFF_FFFF, 32'h0000_0001, SEL_ADD, 1'b0, 32'h0000_0000, 4'b1010);
    run_one("nor", 32'h00FF_0000, 32'h0000_00FF, SEL_NOR, 1'b0, 32'hFF00_FF00, 4'b0100);

    // Stream of 8 XOR ops: one result per cycle, in order
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        drive(sa[k], sb[k], SEL_XOR, 1'b0);
        chk("stream cmd_ready", 64'(cmd_ready), 64'd1);
      end else begin
        cmd_valid = 1'b0;
      end
      if (k >= 3) begin
        chk("stream res_valid", 64'(res_valid), 64'd1);
        chk("stream res_y", 64'(res_y), 64'(sa[k-3] ^ sb[k-3]));
        $display("stream result %0d y=%h", k - 3, res_y);
      end
      tick();
    end
    chk("stream idle", 64'(res_valid), 64'd0);

    // Backpressure: six ops fill FIFO + S1 + S2
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(ba[k], '0, SEL_OR, 1'b0);
      chk("bp cmd_ready fill", 64'(cmd_ready), 64'd1);
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("bp cmd_ready full", 64'(cmd_ready), 64'd0);
      chk("bp res_valid held", 64'(res_valid), 64'd1);
      chk("bp res_y held", 64'(res_y), 64'(ba[0]));
      chk("bp alu_a held", 64'(alu_a), 64'(ba[1]));
      tick();
    end
    // Full edge: push attempted while full and a pop happens on the same edge
    drive(ba[6], '0, SEL_OR, 1'b0);
    res_ready = 1'b1;
    chk("full cmd_ready", 64'(cmd_ready), 64'd0);
    chk("full res_y", 64'(res_y), 64'(ba[0]));
    tick();
    cmd_valid = 1'b0;
    chk("full count", 64'(dut.fifo_count), 64'(DEPTH - 1));
    chk("full cmd_ready after pop", 64'(cmd_ready), 64'd1);
    for (int j = 1; j < 6; j++) begin
      chk("drain res_valid", 64'(res_valid), 64'd1);
      chk("drain res_y", 64'(res_y), 64'(ba[j]));
      $display("drain result %0d y=%h", j, res_y);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("drain no stale", 64'(res_valid), 64'd0);
      tick();
    end

    // Reset with three ops in flight
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'hC000_0000 + k, 32'h1, SEL_ADD, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("midrst busy", 64'(res_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst cmd_ready low", 64'(cmd_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst res_valid", 64'(res_valid), 64'd0);
    chk("midrst res_y", 64'(res_y), 64'd0);
    chk("midrst res_flags", 64'(res_flags), 64'd0);
    chk("midrst alu_a", 64'(alu_a), 64'd0);
    chk("midrst alu_b", 64'(alu_b), 64'd0);
    chk("midrst alu_sel", 64'(alu_sel), 64'd0);
    chk("midrst cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst count", 64'(dut.fifo_count), 64'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst no stale", 64'(res_valid), 64'd0);
    end

`ifdef ALU_CARRY_CHAIN_EN
    // Back-to-back chain: Cout of the first op is live on the ALU at issue
    drive(32'hFFFF_FFFF, 32'h1, SEL_ADD, 1'b0);
    cmd_chain = 1'b0;
    tick();
    drive(32'h0, 32'h0, SEL_ADD, 1'b0);
    cmd_chain = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    chk("chain op1 alu_a", 64'(alu_a), 64'hFFFF_FFFF);
    tick();
    chk("chain b2b alu_cin", 64'(alu_cin), 64'd1);
    chk("chain op1 res_y", 64'(res_y), 64'd0);
    chk("chain op1 flags", 64'(res_flags), 64'b1010);
    tick();
    chk("chain op2 res_y", 64'(res_y), 64'd1);
    $display("chain b2b y=%h flags=%b", res_y, res_flags);
    tick();
    // Two idle cycles: the carry register supplies Cout
    drive(32'hFFFF_FFFF, 32'h1, SEL_ADD, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    drive(32'h0, 32'h0, SEL_ADD, 1'b0);
    cmd_chain = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    tick();
    chk("chain gap alu_cin", 64'(alu_cin), 64'd1);
    tick();
    chk("chain gap res_y", 64'(res_y), 64'd1);
    $display("chain gap y=%h flags=%b", res_y, res_flags);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
